window_rotate_sampler: RTL
==========================

// Module: window_rotate_sampler
// PURPOSE
//  Rotates a square pixel window by any of 36 angles in 10-degree steps, covering the full 360 degrees.
//  Each output pixel is produced by bilinear interpolation of the input window.
//  Accepts one window per valid/ready transaction and streams WIN_W*WIN_W samples, LANES per beat.
//  Sits between the shift-register window extractor and the SIFT descriptor stage.
// PARAMETERS
//  WIN_W       4   window edge, in pixels (>=2)
//  DATA_W      8   input pixel width, unsigned
//  OUT_W       8   output sample width (DATA_W<<(OUT_W-DATA_W), or >> when narrower)
//  INTERP_BITS 4   fractional bits of the x/y interpolation weights
//  LANES       1   samples per output beat; must divide WIN_W*WIN_W
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset
//  in_valid     in   1                    window_in and angle are valid
//  in_ready     out  1                    block can accept a window
//  angle        in   6                    rotation index; 0..35 = 0..350 deg
//  window_in    in   WIN_W*WIN_W*DATA_W   pixel (c,r) at [(r*WIN_W+c)*DATA_W+:DATA_W]
//  out_valid    out  1                    out_samples is valid
//  out_ready    in   1                    consumer accepts the beat
//  out_samples  out  LANES*OUT_W          lane l holds sample index out_idx*LANES+l
//  out_idx      out  clog2(WIN_W*WIN_W/LANES)  beat number
//  out_last     out  1                    final beat of the window
//  busy         out  1                    asserted in every state except IDLE
// BEHAVIOUR
//  Reset: clk, single clock domain; rst is asynchronous, active-high.
//   - While rst is high: in_ready=0, out_valid=0, out_last=0, out_idx=0, out_samples=0, busy=0, FSM=IDLE.
//   - Reset mid-operation aborts the window. No beat is emitted afterwards.
//   - in_ready rises on the first clk edge after rst falls.
//  FSM states:
//   - IDLE: in_ready=1. On in_valid&&in_ready, latch window_in and angle, then go to RUN.
//   - RUN: the address counter issues LANES samples per cycle into a 2-stage interpolator pipeline.
//   - DRAIN: entered after the last address is issued; waits until the last beat is accepted, then returns to IDLE.
//   - No new window is accepted before returning to IDLE, so there is one idle cycle between windows.
//  Angle handling:
//   - Angle values 36..63 wrap to angle-36.
//   - q=angle/9 is the quadrant; s=angle%9 indexes a 9-entry cos/sin table (0..80 deg).
//   - The table is Q1.15 and is built at elaboration time.
//  Sample coordinates for output pixel (gx,gy):
//   - u=gx-(WIN_W-1)/2, v=gy-(WIN_W-1)/2.
//   - Quadrant pre-rotation of (u,v) by q: 0:(u,v) 1:(-v,u) 2:(-u,-v) 3:(v,-u).
//   - x=u*c-v*s+(WIN_W-1)/2, y=u*s+v*c+(WIN_W-1)/2.
//   - Coordinates use signed fixed point with INTERP_BITS fractional bits, truncated toward -inf.
//   - lo=floor, hi=lo+1, alpha=frac.
//   - When alpha=0, hi is not read; this makes x=WIN_W-1 legal.
//   - A sample with lo<0 or hi>WIN_W-1 (with alpha!=0) is out-of-window.
//  Interpolation:
//   - t=p0+(((p1-p0)*xa)>>>INTERP_BITS); b likewise from p2/p3; r=t+(((b-t)*ya)>>>INTERP_BITS).
//   - Signed intermediates are DATA_W+INTERP_BITS+2 bits wide. r is clamped to [0, 2^DATA_W-1] and then scaled to OUT_W.
//  Pipeline and handshake:
//   - Latency is 3 clk from in_valid&&in_ready to the first out_valid, with no backpressure.
//   - out_valid/out_samples/out_idx/out_last stay stable while out_valid&&!out_ready.
//   - The entire pipeline stalls in that case; no beat is dropped or duplicated.
//   - out_idx counts 0..WIN_W*WIN_W/LANES-1. out_last=1 only on the final index.
// CONFIGURATION
//  SAMPLER_BORDER_CLAMP_EN
//   - Defined: out-of-window coordinates are clamped per axis to [0, WIN_W-1] before lo/hi/alpha are derived, so border pixels replicate.
//   - Undefined: out-of-window samples output 0.
// TESTING
//  - T1 identity: WIN_W=4, LANES=1, pixel(c,r)=r*16+c, angle=0 -> 16 beats, beat k=(k/4)*16+k%4, out_last at k=15, first out_valid 3 clk after accept.
//  - T2 90 deg: same window, angle=9 -> sample(gx,gy)=gx*16+(3-gy); angle=18 -> (3-gy)*16+(3-gx); angle=45 behaves as angle=9.
//  - T3 border: angle=4 (40 deg) -> sample 0 out-of-window; output 0 without the macro, a nonzero row-0 replica with SAMPLER_BORDER_CLAMP_EN.
//  - T4 backpressure: angle=0, out_ready toggling 1,0,0,1 -> no gaps or duplicates in the beat sequence; outputs frozen while out_ready=0; 16 beats total.
//  - T5 LANES=4: angle=0 -> 4 beats; beat 1 = {19,18,17,16} (lane3..lane0); in_ready=0 until beat 3 is accepted.
//  - T6 reset: assert rst at beat 6 -> out_valid=0 immediately; a new window after rst starts again at out_idx=0.

Source files
------------

// File: rtl/window_rotate_sampler.sv
// Rotates a WIN_W x WIN_W pixel window by angle*10 degrees and streams bilinear-resampled pixels.
// Optional macro SAMPLER_BORDER_CLAMP_EN: replicate border pixels instead of zeroing out-of-window samples.
module window_rotate_sampler #(
    parameter int WIN_W       = 4,
    parameter int DATA_W      = 8,
    parameter int OUT_W       = 8,
    parameter int INTERP_BITS = 4,
    parameter int LANES       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [5:0]                            angle,
    input  logic [WIN_W*WIN_W*DATA_W-1:0]         window_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES*OUT_W-1:0]                out_samples,
    output logic [$clog2(WIN_W*WIN_W/LANES)-1:0]  out_idx,
    output logic                                  out_last,
    output logic                                  busy
);

    localparam int NPIX   = WIN_W * WIN_W;
    localparam int NBEAT  = NPIX / LANES;
    localparam int IDX_W  = $clog2(NBEAT);
    localparam int IB     = INTERP_BITS;
    localparam int COEF_W = 18;
    localparam int PW     = $clog2(WIN_W) + IB + 3 + COEF_W + 1;
    localparam int SW     = DATA_W + IB + 2;
    localparam int PRW    = 2 * SW;
    localparam int CEN_I  = ((WIN_W - 1) << IB) / 2;
    localparam int MAXC_I = (WIN_W - 1) << IB;
    localparam int UP     = (OUT_W >= DATA_W) ? OUT_W - DATA_W : 0;
    localparam int DN     = (DATA_W > OUT_W) ? DATA_W - OUT_W : 0;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBEAT - 1);

    typedef logic [DATA_W-1:0] pix_t;
    typedef struct packed {
        logic          oow;
        logic [IB-1:0] xa;
        logic [IB-1:0] ya;
        pix_t          p00;
        pix_t          p01;
        pix_t          p10;
        pix_t          p11;
    } tap_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // cos(k*10 deg) in Q1.15; sin(k*10 deg) is cos_q15(9-k)
    function automatic logic signed [COEF_W-1:0] cos_q15(input logic [3:0] k);
        case (k)
            4'd0:    return 18'sd32768;
            4'd1:    return 18'sd32270;
            4'd2:    return 18'sd30792;
            4'd3:    return 18'sd28378;
            4'd4:    return 18'sd25102;
            4'd5:    return 18'sd21063;
            4'd6:    return 18'sd16384;
            4'd7:    return 18'sd11207;
            4'd8:    return 18'sd5690;
            default: return 18'sd0;
        endcase
    endfunction

    function automatic pix_t get_pix(input logic [NPIX*DATA_W-1:0] win, input int c, input int r);
        return win[(r*WIN_W + c)*DATA_W +: DATA_W];
    endfunction

    function automatic tap_t fetch(input int g, input logic [1:0] q,
                                   input logic signed [COEF_W-1:0] cs,
                                   input logic signed [COEF_W-1:0] sn,
                                   input logic [NPIX*DATA_W-1:0] win);
        logic signed [PW-1:0] u, v, ur, vr, xf, yf, x, y, xlo, ylo;
        logic x_oob, y_oob;
        int   xl, yl, xh, yh, ui, vi;
        tap_t tp;
        ui = ((g % WIN_W) << IB) - CEN_I;
        vi = ((g / WIN_W) << IB) - CEN_I;
        u  = PW'(ui);
        v  = PW'(vi);
        case (q)
            2'd0:    begin ur = u;  vr = v;  end
            2'd1:    begin ur = -v; vr = u;  end
            2'd2:    begin ur = -u; vr = -v; end
            default: begin ur = v;  vr = -u; end
        endcase
        xf = ur * PW'(cs) - vr * PW'(sn);
        yf = ur * PW'(sn) + vr * PW'(cs);
        x  = (xf >>> 15) + PW'(CEN_I);
        y  = (yf >>> 15) + PW'(CEN_I);
`ifdef SAMPLER_BORDER_CLAMP_EN
        if (x < 0) x = '0;
        else if (x > PW'(MAXC_I)) x = PW'(MAXC_I);
        if (y < 0) y = '0;
        else if (y > PW'(MAXC_I)) y = PW'(MAXC_I);
`endif
        xlo   = x >>> IB;
        ylo   = y >>> IB;
        tp.xa = x[IB-1:0];
        tp.ya = y[IB-1:0];
        // hi is only read with a nonzero weight, so lo == WIN_W-1 is legal at alpha 0
        x_oob = (xlo < 0) || (xlo > PW'(WIN_W - 1)) || ((tp.xa != '0) && (xlo == PW'(WIN_W - 1)));
        y_oob = (ylo < 0) || (ylo > PW'(WIN_W - 1)) || ((tp.ya != '0) && (ylo == PW'(WIN_W - 1)));
        tp.oow = x_oob || y_oob;
        xl = tp.oow ? 0 : int'(xlo);
        yl = tp.oow ? 0 : int'(ylo);
        xh = (!tp.oow && tp.xa != '0) ? xl + 1 : xl;
        yh = (!tp.oow && tp.ya != '0) ? yl + 1 : yl;
        tp.p00 = get_pix(win, xl, yl);
        tp.p01 = get_pix(win, xh, yl);
        tp.p10 = get_pix(win, xl, yh);
        tp.p11 = get_pix(win, xh, yh);
        return tp;
    endfunction

    function automatic logic signed [SW-1:0] widen(input pix_t p);
        return $signed({{(SW-DATA_W){1'b0}}, p});
    endfunction

    function automatic logic signed [SW-1:0] lerp(input logic signed [SW-1:0] a,
                                                  input logic signed [SW-1:0] b,
                                                  input logic [IB-1:0] w);
        logic signed [PRW-1:0] prod;
        prod = PRW'(b - a) * PRW'($signed({1'b0, w}));
        return a + SW'(prod >>> IB);
    endfunction

    function automatic pix_t sat(input logic signed [SW-1:0] r);
        if (r < 0) return '0;
        if (r > SW'((1 << DATA_W) - 1)) return '1;
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] scale(input pix_t p);
        logic [DATA_W+UP-1:0] wide;
        wide = (DATA_W+UP)'(p) << UP;
        return OUT_W'(wide >> DN);
    endfunction

    function automatic logic [OUT_W-1:0] out_pix(input logic signed [SW-1:0] t,
                                                 input logic signed [SW-1:0] b,
                                                 input logic [IB-1:0] ya, input logic oow);
        return oow ? '0 : scale(sat(lerp(t, b, ya)));
    endfunction

    state_t                   state, state_nxt;
    logic                     armed, issue, accept, adv;
    logic [IDX_W-1:0]         addr;
    logic [NPIX*DATA_W-1:0]   win_r;
    logic [1:0]               q_r;
    logic [3:0]               s_r;
    logic [5:0]               ang_w;
    logic signed [COEF_W-1:0] cs, sn;
    tap_t                     tap_w  [LANES];
    tap_t                     tap_p0 [LANES];
    logic signed [SW-1:0]     t_p1   [LANES];
    logic signed [SW-1:0]     b_p1   [LANES];
    logic [IB-1:0]            ya_p1  [LANES];
    logic                     oow_p1 [LANES];
    logic [IDX_W-1:0]         idx_p0, idx_p1;
    logic                     last_p0, last_p1, vld_p0, vld_p1;
    logic [LANES*OUT_W-1:0]   samp_w;

    assign adv    = !(out_valid && !out_ready);
    assign accept = in_valid && in_ready;
    assign ang_w  = (angle >= 6'd36) ? angle - 6'd36 : angle;
    assign cs     = cos_q15(s_r);
    assign sn     = cos_q15(4'd9 - s_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) addr <= '0;
            else if (issue) addr <= (addr == LAST) ? '0 : addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (issue && addr == LAST) state_nxt = DRAIN;
            DRAIN:   if (out_valid && out_ready && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = armed && (state == IDLE);
        busy     = (state != IDLE);
        issue    = (state == RUN) && adv;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win_r <= window_in;
            q_r   <= 2'(ang_w / 6'd9);
            s_r   <= 4'(ang_w % 6'd9);
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++)
            tap_w[l] = fetch(int'(addr) * LANES + l, q_r, cs, sn, win_r);
    end

    // p0: coordinates and tap fetch; p1: horizontal blend
    always_ff @(posedge clk) begin
        if (adv) begin
            tap_p0  <= tap_w;
            idx_p0  <= addr;
            last_p0 <= (addr == LAST);
            for (int l = 0; l < LANES; l++) begin
                t_p1[l]   <= lerp(widen(tap_p0[l].p00), widen(tap_p0[l].p01), tap_p0[l].xa);
                b_p1[l]   <= lerp(widen(tap_p0[l].p10), widen(tap_p0[l].p11), tap_p0[l].xa);
                ya_p1[l]  <= tap_p0[l].ya;
                oow_p1[l] <= tap_p0[l].oow;
            end
            idx_p1  <= idx_p0;
            last_p1 <= last_p0;
        end
    end

    always_comb begin
        samp_w = '0;
        for (int l = 0; l < LANES; l++)
            samp_w[l*OUT_W +: OUT_W] = out_pix(t_p1[l], b_p1[l], ya_p1[l], oow_p1[l]);
    end

    // p2: vertical blend, clamp and scale into the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            out_samples <= '0;
        end else if (adv) begin
            vld_p0      <= issue;
            vld_p1      <= vld_p0;
            out_valid   <= vld_p1;
            out_idx     <= idx_p1;
            out_last    <= last_p1 && vld_p1;
            out_samples <= samp_w;
        end
    end

endmodule
